// File: rtl/timer_ctrl.sv
// Control FSM for an MM:SS countdown timer: BCD preset entry, run/pause,
// and a tick-timed alarm window after expiry.
module timer_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        increase,
  input  logic        mode,
  input  logic        tick,
  input  logic        count_zero,
  output logic [15:0] preset,
  output logic        load,
  output logic        dec_en,
  output logic        alarm,
  output logic [2:0]  state
);

  localparam int CW = $clog2(ALARM_TICKS + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET     = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  logic [2:0]    state_reg;
  logic [CW-1:0] alarm_cnt;

  // One-second increment of a BCD MM:SS value; 59:59 rolls over to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = (m1 != 4'd5) ? m1 + 4'd1 : 4'd0;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      preset    <= 16'h0000;
      load      <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      // load and alarm are rebuilt every cycle so they cannot linger.
      load  <= 1'b0;
      alarm <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mode) begin
            state_reg <= SET;
          end else if (start && (preset != 16'h0000)) begin
            state_reg <= RUN;
            load      <= 1'b1;
          end
        end
        SET: begin
          if (increase) preset <= bcd_inc(preset);
          if (!mode) state_reg <= IDLE;
        end
        RUN: begin
          if (count_zero) begin
            state_reg <= EXPIRED;
            alarm     <= 1'b1;
            alarm_cnt <= '0;
          end else if (start) begin
            state_reg <= PAUSE;
          end
        end
        PAUSE: begin
          if (mode) begin
            state_reg <= SET;
          end else if (start) begin
            state_reg <= RUN;
          end
        end
        EXPIRED: begin
          if (start || (tick && (alarm_cnt == LAST_TICK))) begin
            state_reg <= IDLE;
            alarm_cnt <= '0;
          end else begin
            alarm <= 1'b1;
            // Exit happens at LAST_TICK, so the counter never reaches wrap.
            if (tick) alarm_cnt <= alarm_cnt + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign state  = state_reg;
  assign dec_en = (state_reg == RUN) & tick & ~count_zero;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl: expectations are queued as each
// step is driven and drained once the DUT has had its clock edge.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        increase = 1'b0;
  logic        mode = 1'b0;
  logic        tick = 1'b0;
  logic        count_zero = 1'b0;
  logic [15:0] preset;
  logic        load;
  logic        dec_en;
  logic        alarm;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  timer_ctrl #(.ALARM_TICKS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .increase(increase),
    .mode(mode), .tick(tick), .count_zero(count_zero),
    .preset(preset), .load(load), .dec_en(dec_en), .alarm(alarm),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam int S_STATE = 0, S_PRESET = 1, S_LOAD = 2, S_ALARM = 3, S_DEC = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_STATE:  return {13'd0, state};
      S_PRESET: return preset;
      S_LOAD:   return {15'd0, load};
      S_ALARM:  return {15'd0, alarm};
      default:  return {15'd0, dec_en};
    endcase
  endfunction

  // Independent reference: seconds count converted to BCD MM:SS.
  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = (secs % 3600) / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = observe(e.sel);
      tests++;
      assert (got === e.val)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, got, e.val);
      end
    end
  endtask

  // Drive one cycle of inputs at negedge; pulses drop just after the edge.
  task automatic step(input logic st, input logic inc, input logic md,
                      input logic tk, input logic cz);
    @(negedge clk);
    start = st; increase = inc; mode = md; tick = tk; count_zero = cz;
    @(posedge clk);
    #1;
    start = 1'b0; increase = 1'b0; tick = 1'b0;
  endtask

  task automatic expect_fsm(input string tag, input logic [2:0] st, input logic al);
    push({tag, ".state"}, S_STATE, {13'd0, st});
    push({tag, ".alarm"}, S_ALARM, {15'd0, al});
    drain();
  endtask

  int secs;

  initial begin
    // Reset state, with tick high to show dec_en is gated by state.
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push("rst.state", S_STATE, 16'd0);
    push("rst.preset", S_PRESET, 16'h0000);
    push("rst.load", S_LOAD, 16'd0);
    push("rst.alarm", S_ALARM, 16'd0);
    push("rst.dec_en", S_DEC, 16'd0);
    drain();
    @(negedge clk);
    reset = 1'b1;
    tick = 1'b0;

    // Zero preset: start ignored.
    push("zero.state", S_STATE, 16'd0);
    push("zero.load", S_LOAD, 16'd0);
    step(1, 0, 0, 0, 0);
    drain();
    push("zero.load2", S_LOAD, 16'd0);
    step(0, 0, 0, 0, 0);
    drain();

    // Enter SET and sweep the preset all the way round to 00:05.
    push("set.enter", S_STATE, 16'd1);
    step(0, 0, 1, 0, 0);
    drain();
    push("set.start_ign", S_STATE, 16'd1);
    step(1, 0, 1, 0, 0);
    drain();
    secs = 0;
    for (int i = 0; i < 3605; i++) begin
      secs++;
      push("set.inc", S_PRESET, to_bcd(secs));
      step(0, 1, 1, 0, 0);
      drain();
      if (secs == 3598) begin
        push("wrap.5958", S_PRESET, 16'h5958); drain();
      end
      if (secs == 3599) begin
        push("wrap.5959", S_PRESET, 16'h5959); drain();
      end
      if (secs == 3600) begin
        push("wrap.0000", S_PRESET, 16'h0000); drain();
      end
    end
    push("set.final", S_PRESET, 16'h0005);
    drain();

    // Leave SET; increase outside SET is ignored.
    push("idle.back", S_STATE, 16'd0);
    step(0, 0, 0, 0, 0);
    drain();
    push("idle.inc_ign", S_PRESET, 16'h0005);
    step(0, 1, 0, 0, 0);
    drain();

    // Start with non-zero preset: RUN with a one-cycle load.
    push("run.state", S_STATE, 16'd2);
    push("run.load", S_LOAD, 16'd1);
    step(1, 0, 0, 0, 0);
    drain();
    push("run.load_drop", S_LOAD, 16'd0);
    step(0, 0, 0, 0, 0);
    drain();

    // Tick in RUN with count_zero=0 raises dec_en combinationally.
    @(negedge clk);
    tick = 1'b1;
    #1;
    push("run.dec_en", S_DEC, 16'd1);
    drain();
    @(posedge clk);
    #1;
    tick = 1'b0;
    #1;
    push("run.dec_idle", S_DEC, 16'd0);
    drain();

    // mode and increase ignored in RUN.
    push("run.mode_ign", S_STATE, 16'd2);
    push("run.inc_ign", S_PRESET, 16'h0005);
    step(0, 1, 1, 0, 0);
    drain();

    // Pause; ticks in PAUSE give no dec_en.
    push("pause.state", S_STATE, 16'd3);
    step(1, 0, 0, 0, 0);
    drain();
    @(negedge clk);
    tick = 1'b1;
    #1;
    push("pause.dec_en", S_DEC, 16'd0);
    drain();
    @(posedge clk);
    #1;
    tick = 1'b0;
    push("pause.hold", S_STATE, 16'd3);
    drain();

    // Resume without a load pulse.
    push("resume.state", S_STATE, 16'd2);
    push("resume.load", S_LOAD, 16'd0);
    step(1, 0, 0, 0, 0);
    drain();

    // Expiry beats start; alarm holds for exactly 10 ticks.
    step(1, 0, 0, 0, 1);
    expect_fsm("exp.enter", 3'd4, 1'b1);
    @(negedge clk);
    tick = 1'b1;
    #1;
    push("exp.dec_en", S_DEC, 16'd0);
    drain();
    @(posedge clk);
    #1;
    tick = 1'b0;
    expect_fsm("exp.tick1", 3'd4, 1'b1);
    for (int t = 2; t <= 9; t++) begin
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      expect_fsm($sformatf("exp.tick%0d", t), 3'd4, 1'b1);
    end
    step(0, 0, 0, 1, 0);
    expect_fsm("exp.tick10", 3'd0, 1'b0);
    push("exp.preset", S_PRESET, 16'h0005);
    drain();

    // Acknowledge after 3 ticks.
    step(1, 0, 0, 0, 0);
    expect_fsm("ack.run", 3'd2, 1'b0);
    step(0, 0, 0, 0, 1);
    expect_fsm("ack.exp", 3'd4, 1'b1);
    for (int t = 0; t < 3; t++) step(0, 0, 0, 1, 1);
    expect_fsm("ack.3ticks", 3'd4, 1'b1);
    step(1, 0, 0, 0, 0);
    expect_fsm("ack.idle", 3'd0, 1'b0);
    push("ack.preset", S_PRESET, 16'h0005);
    drain();

    // Abort from PAUSE into SET.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    push("abort.pause", S_STATE, 16'd3);
    drain();
    push("abort.set", S_STATE, 16'd1);
    step(1, 0, 1, 0, 0);
    drain();
    push("abort.idle", S_STATE, 16'd0);
    step(0, 0, 0, 0, 0);
    drain();

    // Asynchronous reset between edges in RUN.
    push("areset.run", S_STATE, 16'd2);
    step(1, 0, 0, 0, 0);
    drain();
    @(negedge clk);
    tick = 1'b1;
    #1;
    push("areset.pre_dec", S_DEC, 16'd1);
    drain();
    #2;
    reset = 1'b0;
    #1;
    push("areset.state", S_STATE, 16'd0);
    push("areset.dec_en", S_DEC, 16'd0);
    push("areset.preset", S_PRESET, 16'h0000);
    push("areset.load", S_LOAD, 16'd0);
    push("areset.alarm", S_ALARM, 16'd0);
    drain();
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    push("post.zero_start", S_STATE, 16'd0);
    push("post.load", S_LOAD, 16'd0);
    step(1, 0, 0, 0, 0);
    drain();
    push("post.set", S_STATE, 16'd1);
    step(0, 0, 1, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
